// File: rtl/chan_mux_pkg.sv
// Shared constants and types for the channel multiplexer: status-channel
// address, clear command, channel limit and status FSM encoding.
package chan_mux_pkg;

    localparam logic [6:0] STATUS_ADDR  = 7'h7F;
    localparam logic [7:0] CLEAR_CMD    = 8'h00;
    localparam int         NUM_CHAN_MAX = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DUMP = 1'b1
    } stat_state_t;

    // Number of bytes the status channel streams out for one full dump.
    function automatic int dump_bytes(input int num_chan, input int cnt_w);
        return num_chan * (cnt_w / 8);
    endfunction

endpackage

// File: rtl/chan_mux_if.sv
// Host-link channel bus plus the per-channel FIFO-style source/sink signals.
// master = host link and channel endpoints, slave = the multiplexer.
interface chan_mux_if #(
    parameter int NUM_CHAN = 4
);
    logic [6:0]            chanAddr_in;
    logic [7:0]            chanData_in;
    logic                  chanWrite_in;
    logic                  chanGotRoom_out;
    logic [7:0]            chanData_out;
    logic                  chanRead_in;
    logic                  chanGotData_out;
    logic [8*NUM_CHAN-1:0] rdData_in;
    logic [NUM_CHAN-1:0]   rdValid_in;
    logic [NUM_CHAN-1:0]   rdAck_out;
    logic [7:0]            wrData_out;
    logic [NUM_CHAN-1:0]   wrValid_out;
    logic [NUM_CHAN-1:0]   wrReady_in;

    modport master (
        output chanAddr_in, chanData_in, chanWrite_in, chanRead_in,
               rdData_in, rdValid_in, wrReady_in,
        input  chanGotRoom_out, chanData_out, chanGotData_out,
               rdAck_out, wrData_out, wrValid_out
    );

    modport slave (
        input  chanAddr_in, chanData_in, chanWrite_in, chanRead_in,
               rdData_in, rdValid_in, wrReady_in,
        output chanGotRoom_out, chanData_out, chanGotData_out,
               rdAck_out, wrData_out, wrValid_out
    );
endinterface

// File: rtl/chan_mux_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            q_reg <= '0;
        end else if (inc && (q_reg != '1)) begin
            q_reg <= q_reg + W'(1);
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/chan_mux.sv
// Channel multiplexer: routes the host-link channel bus to NUM_CHAN byte
// sources/sinks, counts accepted bytes per channel, and exposes the counts on 7'h7F.
module chan_mux
    import chan_mux_pkg::*;
#(
    parameter int NUM_CHAN = 4,
    parameter int CNT_W    = 16
) (
    input  logic       clk_in,
    input  logic       reset_in,
    chan_mux_if.slave  bus
);

    localparam int DUMP_BYTES = dump_bytes(NUM_CHAN, CNT_W);
    localparam int PTR_W      = (DUMP_BYTES > 1) ? $clog2(DUMP_BYTES) : 1;
    localparam int ADDR_SPAN  = (NUM_CHAN < NUM_CHAN_MAX) ? NUM_CHAN : NUM_CHAN_MAX;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DUMP_BYTES - 1);

    logic [NUM_CHAN-1:0]       hit;
    logic [NUM_CHAN-1:0]       rd_ack;
    logic [NUM_CHAN-1:0]       wr_valid;
    logic [NUM_CHAN*CNT_W-1:0] count_flat;

    logic                      is_status;
    logic                      is_mapped;
    logic                      status_rd;
    logic                      status_clr;

    logic [7:0]                sel_data;
    logic                      sel_valid;
    logic                      sel_ready;
    logic [7:0]                stat_byte;

    stat_state_t               state_reg, state_next;
    logic [PTR_W-1:0]          ptr_reg, ptr_next;
    logic [NUM_CHAN*CNT_W-1:0] shadow_reg;
    logic                      snap;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign is_status  = (bus.chanAddr_in == STATUS_ADDR);
    assign is_mapped  = (bus.chanAddr_in < 7'(ADDR_SPAN));
    assign status_rd  = is_status && bus.chanRead_in;
    assign status_clr = is_status && bus.chanWrite_in && (bus.chanData_in == CLEAR_CMD);

    generate
        for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
            assign hit[gi]      = (bus.chanAddr_in == 7'(gi));
            assign rd_ack[gi]   = bus.chanRead_in  && bus.rdValid_in[gi] && hit[gi];
            assign wr_valid[gi] = bus.chanWrite_in && bus.wrReady_in[gi] && hit[gi];

            sat_counter #(
                .W(CNT_W)
            ) u_cnt (
                .clk  (clk_in),
                .srst (reset_in),
                .inc  (rd_ack[gi] || wr_valid[gi]),
                .clr  (status_clr),
                .q    (count_flat[gi*CNT_W +: CNT_W])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Data-channel selection
    // ------------------------------------------------------------------
    always_comb begin
        sel_data  = 8'h00;
        sel_valid = 1'b0;
        sel_ready = 1'b0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            if (hit[i]) begin
                sel_data  = bus.rdData_in[8*i +: 8];
                sel_valid = bus.rdValid_in[i];
                sel_ready = bus.wrReady_in[i];
            end
        end
    end

    // In IDLE the first byte comes from the live counter so the host sees
    // it with zero latency; the rest of the dump comes from the snapshot.
    assign stat_byte = (state_reg == ST_IDLE) ? count_flat[7:0]
                                              : shadow_reg[{ptr_reg, 3'b000} +: 8];

    always_comb begin
        if (is_status) begin
            bus.chanData_out    = stat_byte;
            bus.chanGotData_out = 1'b1;
            bus.chanGotRoom_out = 1'b1;
        end else if (is_mapped) begin
            bus.chanData_out    = sel_data;
            bus.chanGotData_out = sel_valid;
            bus.chanGotRoom_out = sel_ready;
        end else begin
            bus.chanData_out    = 8'h00;
            bus.chanGotData_out = 1'b0;
            bus.chanGotRoom_out = 1'b1;
        end
    end

    assign bus.rdAck_out   = rd_ack;
    assign bus.wrValid_out = wr_valid;
    assign bus.wrData_out  = bus.chanData_in;

    // ------------------------------------------------------------------
    // Status dump FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        snap       = 1'b0;
        if (status_clr) begin
            state_next = ST_IDLE;
            ptr_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (status_rd) begin
                        snap = 1'b1;
                        // A single-byte dump is complete after the live byte.
                        if (DUMP_BYTES > 1) begin
                            state_next = ST_DUMP;
                            ptr_next   = PTR_W'(1);
                        end
                    end
                end
                ST_DUMP: begin
                    if (!is_status) begin
                        state_next = ST_IDLE;
                        ptr_next   = '0;
                    end else if (status_rd) begin
                        if (ptr_reg == LAST_PTR) begin
                            state_next = ST_IDLE;
                            ptr_next   = '0;
                        end else begin
                            ptr_next = ptr_reg + PTR_W'(1);
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    ptr_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_reg  <= ST_IDLE;
            ptr_reg    <= '0;
            shadow_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            if (snap) begin
                shadow_reg <= count_flat;
            end
        end
    end

endmodule
